// File: rtl/cpu_sys_nios2_qsys_0_jtag_debug_host.sv
// cpu_sys_nios2_qsys_0_jtag_debug_host: sequences one virtual-JTAG IR/DR scan per request into the Nios II debug module.
// Define CPU_SYS_JTAG_HOST_TDO_CAPTURE_EN to capture vji_tdo/vji_ir_out; otherwise rsp_dr/rsp_ir_out read as 0.
module cpu_sys_nios2_qsys_0_jtag_debug_host #(
  parameter int TCK_DIV = 2,
  parameter int DR_LEN  = 38
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_ir,
  input  logic [DR_LEN-1:0] cmd_dr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DR_LEN-1:0] rsp_dr,
  output logic [1:0]        rsp_ir_out,
  output logic              vji_tck,
  output logic              vji_tdi,
  output logic              vji_rti,
  output logic              vji_uir,
  output logic              vji_cdr,
  output logic              vji_sdr,
  output logic              vji_udr,
  output logic [1:0]        vji_ir_in,
  input  logic              vji_tdo,
  input  logic [1:0]        vji_ir_out
);
  localparam int BW = $clog2(DR_LEN + 1);
  typedef enum logic [2:0] {IDLE, UIR, CDR, SDR, UDR, RSP} state_t;
  state_t            state_q, state_d;
  logic [7:0]        div_q, div_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic              tck_q, tck_d;
  logic [1:0]        ir_q, ir_d;
  logic [DR_LEN-1:0] sh_q, sh_d;
  logic              active, half_end, rise, period_end, last_bit, accept;
  assign active     = state_q inside {UIR, CDR, SDR, UDR};
  assign half_end   = active && div_q == 8'(TCK_DIV - 1);
  assign rise       = half_end && !tck_q;
  assign period_end = half_end && tck_q;
  assign last_bit   = bit_q == BW'(DR_LEN - 1);
  assign accept     = cmd_valid && state_q == IDLE;
  always_comb begin
    div_d = (active && !half_end) ? 8'(div_q + 8'd1) : 8'd0;
    tck_d = active && (tck_q ^ half_end);
    ir_d  = accept ? cmd_ir : ir_q;
    sh_d  = accept ? cmd_dr : (state_q == SDR && period_end) ? sh_q >> 1 : sh_q;
    bit_d = (state_q == SDR && period_end) ? (last_bit ? '0 : bit_q + 1'b1) : bit_q;
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = accept ? UIR : IDLE;
      UIR:     state_d = period_end ? CDR : UIR;
      CDR:     state_d = period_end ? SDR : CDR;
      SDR:     state_d = (period_end && last_bit) ? UDR : SDR;
      UDR:     state_d = period_end ? RSP : UDR;
      RSP:     state_d = rsp_ready ? IDLE : RSP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      tck_q   <= 1'b0;
      ir_q    <= '0;
      sh_q    <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      tck_q   <= tck_d;
      ir_q    <= ir_d;
      sh_q    <= sh_d;
    end
  end
  assign cmd_ready = state_q == IDLE;
  assign vji_rti   = state_q == IDLE;
  assign rsp_valid = state_q == RSP;
  assign vji_uir   = state_q == UIR;
  assign vji_cdr   = state_q == CDR;
  assign vji_sdr   = state_q == SDR;
  assign vji_udr   = state_q == UDR;
  assign vji_tck   = tck_q;
  assign vji_tdi   = vji_sdr & sh_q[0];
  assign vji_ir_in = ir_q;
`ifdef CPU_SYS_JTAG_HOST_TDO_CAPTURE_EN
  // tdo enters at the MSB so that after DR_LEN rises bit k holds period k's sample
  logic [DR_LEN-1:0] cap_q;
  logic [1:0]        irc_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap_q <= '0;
      irc_q <= '0;
    end else begin
      if (rise && state_q == SDR) cap_q <= {vji_tdo, cap_q[DR_LEN-1:1]};
      if (rise && state_q == UIR) irc_q <= vji_ir_out;
    end
  end
  assign rsp_dr     = cap_q;
  assign rsp_ir_out = irc_q;
`else
  logic unused_tdo;
  assign unused_tdo = ^{vji_tdo, vji_ir_out, rise};
  assign rsp_dr     = '0;
  assign rsp_ir_out = '0;
`endif
endmodule

// File: tb/tb_cpu_sys_nios2_qsys_0_jtag_debug_host.sv
// tb_cpu_sys_nios2_qsys_0_jtag_debug_host: randomized and directed scans checked against a cycle-count model of the scan timeline.
module tb_cpu_sys_nios2_qsys_0_jtag_debug_host;
  localparam int T = 2, N = 38, P = 2 * T, LAT = (N + 3) * P;
`ifdef CPU_SYS_JTAG_HOST_TDO_CAPTURE_EN
  localparam bit CAP = 1'b1;
`else
  localparam bit CAP = 1'b0;
`endif
  logic clk = 1'b0, reset_n = 1'b0;
  always #5 clk = ~clk;
  logic d_cv = 0, d_rr = 0, r_cv = 0, r_rr = 0, rnd = 0, lb = 0, force_ir = 0, rnd_tdo = 0;
  logic [1:0] d_ir = 0, r_ir = 0, rnd_ir = 0;
  logic [N-1:0] d_dr = 0, r_dr = 0, shm = 0;
  logic cmd_valid, cmd_ready, rsp_valid, rsp_ready, vji_tck, vji_tdi, vji_rti, vji_uir, vji_cdr, vji_sdr, vji_udr, vji_tdo;
  logic [1:0] cmd_ir, rsp_ir_out, vji_ir_in, vji_ir_out;
  logic [N-1:0] cmd_dr, rsp_dr;
  assign cmd_valid  = rnd ? r_cv : d_cv;
  assign rsp_ready  = rnd ? r_rr : d_rr;
  assign cmd_ir     = rnd ? r_ir : d_ir;
  assign cmd_dr     = rnd ? r_dr : d_dr;
  assign vji_tdo    = lb ? shm[0] : rnd_tdo;
  assign vji_ir_out = force_ir ? 2'b10 : rnd_ir;
  cpu_sys_nios2_qsys_0_jtag_debug_host #(.TCK_DIV(T), .DR_LEN(N)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir), .cmd_dr(cmd_dr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dr(rsp_dr), .rsp_ir_out(rsp_ir_out),
    .vji_tck(vji_tck), .vji_tdi(vji_tdi), .vji_rti(vji_rti), .vji_uir(vji_uir), .vji_cdr(vji_cdr),
    .vji_sdr(vji_sdr), .vji_udr(vji_udr), .vji_ir_in(vji_ir_in), .vji_tdo(vji_tdo), .vji_ir_out(vji_ir_out));
  logic e1 = 0;
  logic c1_ready, c1_rv, c1_tck, c1_tdi, c1_rti, c1_uir, c1_cdr, c1_sdr, c1_udr;
  logic [1:0] c1_irout, c1_irin;
  logic [N-1:0] c1_dr;
  cpu_sys_nios2_qsys_0_jtag_debug_host #(.TCK_DIV(1), .DR_LEN(N)) dut1 (
    .clk(clk), .reset_n(reset_n), .cmd_valid(e1), .cmd_ready(c1_ready), .cmd_ir(2'b11), .cmd_dr({N{1'b1}}),
    .rsp_valid(c1_rv), .rsp_ready(1'b1), .rsp_dr(c1_dr), .rsp_ir_out(c1_irout),
    .vji_tck(c1_tck), .vji_tdi(c1_tdi), .vji_rti(c1_rti), .vji_uir(c1_uir), .vji_cdr(c1_cdr),
    .vji_sdr(c1_sdr), .vji_udr(c1_udr), .vji_ir_in(c1_irin), .vji_tdo(1'b0), .vji_ir_out(2'b00));
  int n_chk = 0, n_fail = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(posedge clk) begin
    #1;
    rnd_tdo = 1'($urandom);
    rnd_ir  = 2'($urandom);
    r_cv    = ($urandom % 3) == 0;
    r_rr    = ($urandom % 4) == 0;
    r_ir    = 2'($urandom);
    r_dr    = {6'($urandom), 32'($urandom)};
  end
  always @(posedge vji_tck) if (lb && vji_sdr) shm <= {vji_tdi, shm[N-1:1]};
  // Model: mode 0 idle, 1 scanning (c = clk edges since accept), 2 response pending
  int mode = 0, c = 0;
  logic [1:0] m_ir = 0, e_ir = 0;
  logic [N-1:0] m_dr = 0, e_dr = 0;
  always @(posedge clk or negedge reset_n) begin : model
    int nc, p;
    nc = c + 1;
    p = nc / P;
    if (!reset_n) begin
      mode <= 0; c <= 0; m_ir <= 0; e_ir <= 0; e_dr <= '0;
    end else if (mode == 0) begin
      if (cmd_valid) begin mode <= 1; c <= 0; m_ir <= cmd_ir; m_dr <= cmd_dr; end
    end else if (mode == 1) begin
      c <= nc;
      if (nc == LAT) mode <= 2;
      if (nc % P == T && p == 0) e_ir <= vji_ir_out;
      if (nc % P == T && p >= 2 && p < N + 2) e_dr[p-2] <= vji_tdo;
    end else if (rsp_ready) mode <= 0;
  end
  always @(negedge clk) begin : cmp
    int p, ph;
    p = c / P;
    ph = c % P;
    chk("cmd_ready", cmd_ready, mode == 0);
    chk("vji_rti", vji_rti, mode == 0);
    chk("rsp_valid", rsp_valid, mode == 2);
    chk("vji_uir", vji_uir, mode == 1 && p == 0);
    chk("vji_cdr", vji_cdr, mode == 1 && p == 1);
    chk("vji_sdr", vji_sdr, mode == 1 && p >= 2 && p < N + 2);
    chk("vji_udr", vji_udr, mode == 1 && p == N + 2);
    chk("vji_tck", vji_tck, mode == 1 && ph >= T);
    chk("vji_ir_in", vji_ir_in, m_ir);
    if (mode == 1 && p >= 2 && p < N + 2) chk("vji_tdi", vji_tdi, m_dr[p-2]);
    if (mode == 2) begin
      chk("rsp_dr", rsp_dr, CAP ? e_dr : '0);
      chk("rsp_ir_out", rsp_ir_out, CAP ? e_ir : 2'b00);
    end
  end
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic wait_ready(input string name);
    int k;
    k = 0;
    while (!cmd_ready && k < 400) begin tick(1); k++; end
    chk(name, cmd_ready, 1);
  endtask
  initial begin
    int lat;
    logic [3:0] tseq;
    tick(3);
    chk("rst_rsp_dr", rsp_dr, 0);
    chk("rst_rsp_ir", rsp_ir_out, 0);
    chk("rst_rti", vji_rti, 1);
    chk("rst_tck", vji_tck, 0);
    reset_n = 1;
    lb = 1; force_ir = 1; shm = 38'h15_0F0F_3C3C;
    d_ir = 2'b01; d_dr = 38'h2A_5555_AAAA; d_cv = 1;
    tick(1);
    d_cv = 0;
    lat = 0;
    while (!rsp_valid && lat < 400) begin tick(1); lat++; end
    chk("latency", lat, 164);
    chk("loop_rsp_dr", rsp_dr, CAP ? 38'h15_0F0F_3C3C : 38'h0);
    chk("loop_rsp_ir", rsp_ir_out, CAP ? 2'b10 : 2'b00);
    chk("loop_shm", shm, 38'h2A_5555_AAAA);
    force_ir = 0; d_cv = 1;
    repeat (50) begin
      tick(1);
      chk("stall_valid", rsp_valid, 1);
      chk("stall_dr", rsp_dr, CAP ? 38'h15_0F0F_3C3C : 38'h0);
      chk("stall_ready", cmd_ready, 0);
    end
    d_cv = 0; d_rr = 1;
    tick(1);
    d_rr = 0; lb = 0;
    chk("after_rsp_ready", cmd_ready, 1);
    rnd = 1;
    tick(3000);
    rnd = 0; d_rr = 1;
    wait_ready("drain_ready");
    d_rr = 0; d_dr = {6'($urandom), 32'($urandom)}; d_ir = 2'b11; d_cv = 1;
    tick(1);
    d_cv = 0;
    lat = 0;
    while (!vji_sdr && lat < 100) begin tick(1); lat++; end
    chk("reach_sdr", vji_sdr, 1);
    tick(10 * P + 1);
    #2 reset_n = 0;
    #1;
    chk("mid_rst_sdr", vji_sdr, 0);
    chk("mid_rst_tck", vji_tck, 0);
    chk("mid_rst_ready", cmd_ready, 1);
    chk("mid_rst_valid", rsp_valid, 0);
    chk("mid_rst_ir_in", vji_ir_in, 0);
    @(posedge clk); #1;
    reset_n = 1; d_cv = 1;
    tick(1);
    d_cv = 0;
    chk("first_accept", vji_uir, 1);
    d_rr = 1;
    tick(2);
    wait_ready("post_rst_ready");
    d_rr = 0;
    e1 = 1;
    tick(1);
    lat = 0;
    while (!c1_rv && lat < 200) begin tick(1); lat++; end
    chk("t1_latency", lat, 82);
    lat = 0;
    while (!c1_uir && lat < 20) begin tick(1); lat++; end
    chk("t1_restart", lat, 2);
    for (int i = 0; i < 4; i++) begin tseq[i] = c1_tck; tick(1); end
    chk("t1_tck_seq", tseq, 4'b1010);
    e1 = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cpu_sys_nios2_qsys_0_jtag_debug_host.md
CPU_SYS_NIOS2_QSYS_0_JTAG_DEBUG_HOST -- requirements
Module: cpu_sys_nios2_qsys_0_jtag_debug_host

Interface
REQ-001 SHALL have parameter TCK_DIV, 2, clk cycles per tck half-period (legal 1..255).
REQ-002 SHALL have parameter DR_LEN, 38, data-register scan length in bits.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port cmd_valid  input  1  scan request.
REQ-006 SHALL have port cmd_ready  output  1  host idle and able to accept a request.
REQ-007 SHALL have port cmd_ir  input  2  virtual IR value for the scan.
REQ-008 SHALL have port cmd_dr  input  DR_LEN  DR value shifted out, LSB first.
REQ-009 SHALL have port rsp_valid  output  1  scan result available.
REQ-010 SHALL have port rsp_ready  input  1  result consumed.
REQ-011 SHALL have port rsp_dr  output  DR_LEN  DR bits captured from vji_tdo.
REQ-012 SHALL have port rsp_ir_out  output  2  vji_ir_out value sampled during the UIR period.
REQ-013 SHALL have ports vji_tck, vji_tdi, vji_rti, vji_uir, vji_cdr, vji_sdr, vji_udr  output  1 each, and vji_ir_in  output  2: drive the debug-module virtual JTAG inputs.
REQ-014 SHALL have ports vji_tdo  input  1, vji_ir_out  input  2: returned from the debug module.

Function
REQ-015 SHALL implement states IDLE, UIR, CDR, SDR, UDR, RSP; each non-IDLE/RSP period lasts exactly 2*TCK_DIV clk cycles: vji_tck low for the first TCK_DIV cycles, high for the second TCK_DIV cycles.
REQ-016 SHALL assert cmd_ready only in IDLE; a request is accepted on a clk edge with cmd_valid and cmd_ready both high, latching cmd_ir and cmd_dr.
REQ-017 SHALL transition IDLE->UIR on accept, then UIR->CDR->SDR after one period each, SDR->UDR after DR_LEN periods, UDR->RSP after one period, RSP->IDLE on a clk edge with rsp_valid and rsp_ready high.
REQ-018 SHALL assert exactly one of vji_uir/vji_cdr/vji_sdr/vji_udr throughout its matching state; all four low in IDLE and RSP.
REQ-019 SHALL drive vji_ir_in with the latched cmd_ir from UIR entry until the next accept.
REQ-020 SHALL assert vji_rti only in IDLE.
REQ-021 SHALL drive vji_tdi with latched DR bit k during SDR period k (k=0..DR_LEN-1), changing only while vji_tck is low.
REQ-022 SHALL sample vji_tdo into rsp_dr bit k on the clk edge at which vji_tck rises in SDR period k.
REQ-023 SHALL sample vji_ir_out into rsp_ir_out on the clk edge at which vji_tck rises in UIR.
REQ-024 SHALL assert rsp_valid only in RSP; rsp_dr and rsp_ir_out held stable while rsp_valid high.
REQ-025 SHALL ignore cmd_valid outside IDLE; a cmd_valid arriving the same cycle RSP exits is not accepted until IDLE.
REQ-026 SHALL use a bit counter of width ceil(log2(DR_LEN+1)) and divider counter of width 8; no wrap beyond terminal counts.

Reset
REQ-027 SHALL, on reset_n low, immediately force state IDLE, vji_tck, vji_tdi, vji_uir, vji_cdr, vji_sdr, vji_udr to 0, vji_ir_in to 0, vji_rti to 1, cmd_ready to 1 (after release), rsp_valid 0, rsp_dr and rsp_ir_out 0, counters 0.
REQ-028 SHALL abort any scan in progress on reset with no rsp_valid generated; first accept possible on first clk edge after reset_n release.

Configuration
REQ-029 SHALL, with macro CPU_SYS_JTAG_HOST_TDO_CAPTURE_EN defined, capture vji_tdo and vji_ir_out per REQ-022/REQ-023.
REQ-030 SHALL, without CPU_SYS_JTAG_HOST_TDO_CAPTURE_EN, tie rsp_dr and rsp_ir_out to 0, omit capture registers, and keep all sequencing and rsp handshake timing identical.

Verification
REQ-031 Reset mid-SDR (bit 10) -> all strobes 0, vji_tck 0, cmd_ready 1 next cycle, no rsp_valid.
REQ-032 TCK_DIV=2, cmd_ir=2'b01, cmd_dr=38'h2A_5555_AAAA, vji_tdo looped from a 38-bit shift model -> rsp_valid rises 164 clk cycles after accept, rsp_dr equals model prior contents, model ends holding 38'h2A_5555_AAAA.
REQ-033 vji_ir_out=2'b10 during UIR -> rsp_ir_out=2'b10.
REQ-034 rsp_ready held low 50 cycles with cmd_valid high -> rsp_valid and rsp_dr stable, cmd_ready 0, no second scan starts.
REQ-035 TCK_DIV=1, back-to-back requests with rsp_ready tied high -> second UIR begins 2 clk cycles after first rsp_valid edge, vji_tck period 2 clks.
REQ-036 Build without CPU_SYS_JTAG_HOST_TDO_CAPTURE_EN, vji_tdo=1 -> rsp_dr=0, rsp_ir_out=0, same 164-cycle latency.
